// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and default timing constants for the PLL lock sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        PWRUP     = 3'd2,
        INIT      = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_state_t;

    localparam int LOCK_STABLE_CYCLES_D = 1024;
    localparam int PWRUP_CYCLES_D       = 28080;  // 200 us at 140.4 MHz
    localparam int INIT_TIMEOUT_D       = 65535;

    // Largest of three values; sizes the shared counter at elaboration time.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer for asynchronous inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - qualifies PLL lock, times SDRAM power-up, handshakes SDRAM init, releases system reset
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_D,
    parameter int PWRUP_CYCLES       = PWRUP_CYCLES_D,
    parameter int INIT_TIMEOUT       = INIT_TIMEOUT_D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       init_done,
    output logic       sdram_rst_n,
    output logic       init_start,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state
);

    localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, PWRUP_CYCLES, INIT_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Each phase ends on the cycle whose count is one short of its length,
    // so the phase lasts exactly its configured number of cycles.
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYCLES - 1);
    localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_TIMEOUT - 1);

    logic          lock_s;
    logic [CW-1:0] cnt;
    pll_state_t    state_q;
    pll_state_t    state_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Next-state decode; lock loss overrides every other event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (lock_s) state_d = STABLE;
            STABLE:    if (cnt == LOCK_LAST) state_d = PWRUP;
            PWRUP:     if (cnt == PWRUP_LAST) state_d = INIT;
            INIT: begin
                if (init_done)
                    state_d = RUN;
                else if (cnt == INIT_LAST)
                    state_d = FAULT;
            end
            RUN:       state_d = RUN;
            FAULT:     state_d = FAULT;
            default:   state_d = WAIT_LOCK;
        endcase
        if (!lock_s)
            state_d = WAIT_LOCK;
    end

    // State, shared counter and outputs all decoded from the next state so they move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            cnt         <= '0;
            sdram_rst_n <= 1'b0;
            init_start  <= 1'b0;
            sys_rst_n   <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt <= '0;
            else if (state_q == STABLE || state_q == PWRUP || state_q == INIT)
                cnt <= cnt + 1'b1;
            sdram_rst_n <= (state_d == PWRUP) || (state_d == INIT) || (state_d == RUN);
            init_start  <= (state_d == INIT) && (state_q != INIT);
            sys_rst_n   <= (state_d == RUN);
            ready       <= (state_d == RUN);
            fault       <= (state_d == FAULT);
        end
    end

    assign state = state_q;

endmodule
